bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/disp_pkg.sv | 16 +
 rtl/bcd_digit_adj.sv | 9 +
 rtl/bin_to_bcd_seq.sv | 107 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants and state type for the binary-to-BCD display path.
package disp_pkg;

  localparam int BIN_W      = 14;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  localparam logic [3:0]       ITER_LAST   = 4'd13;
  localparam logic [BIN_W-1:0] BCD_MAX_BIN = 14'd9999;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD nibble: add 3 when the digit is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  assign adj = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter, one double-dabble step per clock.
// Optional build macro BCD_SATURATE_EN clamps out-of-range results to 9999.
module bin_to_bcd_seq
  import disp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIN_W-1:0] in_bin,
  output logic [BCD_W-1:0] out_bcd,
  output logic             out_valid,
  output logic             ovf
);

  state_t state, state_next;

  logic             accept;
  logic             last_iter;
  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] scratch_q;
  logic [BCD_W-1:0] scratch_adj;
  logic [BCD_W-1:0] scratch_shift;
  logic [BCD_W-1:0] final_bcd;
  logic [3:0]       cnt_q;
  logic             ovf_pend;

  for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (scratch_q[4*d +: 4]),
      .adj   (scratch_adj[4*d +: 4])
    );
  end

  // The bit leaving the thousands nibble is dropped, which yields in_bin mod 10000.
  assign scratch_shift = {scratch_adj[BCD_W-2:0], bin_q[BIN_W-1]};

  always_comb begin
`ifdef BCD_SATURATE_EN
    final_bcd = ovf_pend ? 16'h9999 : scratch_shift;
`else
    final_bcd = scratch_shift;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    last_iter  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == ITER_LAST) begin
          last_iter  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_pend  <= 1'b0;
      out_bcd   <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        bin_q     <= in_bin;
        scratch_q <= '0;
        cnt_q     <= '0;
        ovf_pend  <= (in_bin > BCD_MAX_BIN);
      end else if (state == SHIFT) begin
        scratch_q <= scratch_shift;
        bin_q     <= {bin_q[BIN_W-2:0], 1'b0};
        cnt_q     <= cnt_q + 4'd1;
        // Results only change here, so the display sees stable data between conversions.
        if (last_iter) begin
          out_bcd   <= final_bcd;
          ovf       <= ovf_pend;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq; honours BCD_SATURATE_EN when defined.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] in_bin;
  logic [15:0] out_bcd;
  logic        out_valid;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs [8];

  bin_to_bcd_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_bcd   (out_bcd),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] refModel(input int v);
    int m;
`ifdef BCD_SATURATE_EN
    m = (v > 9999) ? 9999 : v;
`else
    m = v % 10000;
`endif
    return 16'((m / 1000) * 4096 + ((m / 100) % 10) * 256 + ((m / 10) % 10) * 16 + (m % 10));
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // One conversion: accept, then poke in_valid/in_bin mid-SHIFT, then wait for the pulse.
  task automatic applyStimulus(input logic [13:0] v, output int lat, output logic [15:0] bcd,
                               output logic o, output logic rdy);
    @(negedge clk);
    in_bin   = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bin   = 14'($urandom);
    lat = -1;
    bcd = '0;
    o   = 1'b0;
    rdy = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k >= 2 && k <= 5) begin
        in_valid = 1'b1;
        in_bin   = 14'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        lat = k;
        bcd = out_bcd;
        o   = ovf;
        rdy = in_ready;
        break;
      end
    end
  endtask

  initial begin
    int          lat;
    logic [15:0] bcd;
    logic        o;
    logic        rdy;
    int          pulses;
    int          t0;
    int          t1;
    logic [15:0] b0;
    logic [15:0] b1;
    int          v;

    vecs[0] = '{14'd1234,  16'h1234, 1'b0};
    vecs[1] = '{14'd0,     16'h0000, 1'b0};
    vecs[2] = '{14'd9999,  16'h9999, 1'b0};
`ifdef BCD_SATURATE_EN
    vecs[3] = '{14'd10000, 16'h9999, 1'b1};
    vecs[4] = '{14'd16383, 16'h9999, 1'b1};
    vecs[7] = '{14'd12345, 16'h9999, 1'b1};
`else
    vecs[3] = '{14'd10000, 16'h0000, 1'b1};
    vecs[4] = '{14'd16383, 16'h6383, 1'b1};
    vecs[7] = '{14'd12345, 16'h2345, 1'b1};
`endif
    vecs[5] = '{14'd1,     16'h0001, 1'b0};
    vecs[6] = '{14'd8191,  16'h8191, 1'b0};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset in_ready", int'(in_ready), 1);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset out_bcd", int'(out_bcd), 0);
    checkOutput("reset ovf", int'(ovf), 0);

    $display("[TB] directed vectors");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].bin, lat, bcd, o, rdy);
      checkOutput($sformatf("vec%0d latency", i), lat, 14);
      checkOutput($sformatf("vec%0d out_bcd", i), int'(bcd), int'(vecs[i].bcd));
      checkOutput($sformatf("vec%0d ovf", i), int'(o), int'(vecs[i].ovf));
      checkOutput($sformatf("vec%0d in_ready", i), int'(rdy), 1);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d pulse width", i), int'(out_valid), 0);
      checkOutput($sformatf("vec%0d hold bcd", i), int'(out_bcd), int'(vecs[i].bcd));
    end

    $display("[TB] random vectors");
    for (int n = 0; n < 25; n++) begin
      v = int'($urandom_range(0, 16383));
      applyStimulus(14'(v), lat, bcd, o, rdy);
      checkOutput($sformatf("rand%0d latency", n), lat, 14);
      checkOutput($sformatf("rand%0d out_bcd v=%0d", n, v), int'(bcd), int'(refModel(v)));
      checkOutput($sformatf("rand%0d ovf v=%0d", n, v), int'(o), (v > 9999) ? 1 : 0);
    end

    $display("[TB] back-to-back 5 then 42");
    @(negedge clk);
    in_bin   = 14'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_bin = 14'd42;
    pulses = 0;
    t0 = -1;
    t1 = -1;
    b0 = '0;
    b1 = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 15) begin
        in_valid = 1'b0;
        in_bin   = 14'd7;
      end
      if (out_valid) begin
        if (pulses == 0) begin
          t0 = k;
          b0 = out_bcd;
        end else if (pulses == 1) begin
          t1 = k;
          b1 = out_bcd;
        end
        pulses++;
      end
    end
    checkOutput("b2b pulse count", pulses, 2);
    checkOutput("b2b first time", t0, 14);
    checkOutput("b2b first bcd", int'(b0), 16'h0005);
    checkOutput("b2b second time", t1, 29);
    checkOutput("b2b second bcd", int'(b1), 16'h0042);

    $display("[TB] reset abort of 8888");
    @(negedge clk);
    in_bin   = 14'd8888;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abort in_ready", int'(in_ready), 1);
    checkOutput("abort out_bcd", int'(out_bcd), 0);
    checkOutput("abort ovf", int'(ovf), 0);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    checkOutput("abort no pulse", pulses, 0);

    $display("[TB] reset beats accept");
    @(negedge clk);
    in_bin   = 14'd777;
    in_valid = 1'b1;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b0;
    checkOutput("prio in_ready", int'(in_ready), 1);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    checkOutput("prio no pulse", pulses, 0);

    applyStimulus(14'd4321, lat, bcd, o, rdy);
    checkOutput("post-reset latency", lat, 14);
    checkOutput("post-reset out_bcd", int'(bcd), 16'h4321);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
